// File: rtl/usb2_xfer_sched.sv
// usb2_xfer_sched: per-token transaction scheduler between the USB 2.0 packet
// layer and the endpoint buffer mux. It selects the endpoint, returns the
// GO/NAK/STALL decision, releases IN buffers through the arm handshake and
// pulses the data-toggle advance after each completed transfer.
// Optional build macro: USB2_SCHED_STATS_EN adds the saturating nak_count port.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | waiting for a token; sel_endp holds its last value
// S_SEL       | one-cycle settle of the endpoint mux after selection
// S_CHECK     | sample buffer status, latch GO/NAK/STALL decision
// S_RESP      | present tok_resp_valid / tok_resp for one cycle
// S_WAIT_DONE | GO issued, waiting for xfer_done or xfer_abort
// S_ARM       | buf_out_arm held until ack or timeout
// S_TOGGLE    | one-cycle data_toggle_act pulse

module usb2_xfer_sched #(
   parameter int unsigned NUM_ENDP    = 3,
   parameter logic [15:0] IN_MASK     = 16'h0003,
   parameter logic [15:0] OUT_MASK    = 16'h0005,
   parameter int unsigned ARM_TIMEOUT = 15
) (
   input  logic        phy_clk,
   input  logic        reset_n,
   input  logic        tok_valid,
   input  logic [3:0]  tok_endp,
   input  logic        tok_in,
   input  logic        tok_setup,
   input  logic        xfer_done,
   input  logic        xfer_abort,
   input  logic        buf_out_hasdata,
   input  logic        buf_in_ready,
   input  logic        buf_out_arm_ack,
   output logic [3:0]  sel_endp,
   output logic        buf_out_arm,
   output logic        data_toggle_act,
   output logic        tok_resp_valid,
   output logic [1:0]  tok_resp,
   output logic        busy,
   output logic        err_overrun,
   output logic        err_timeout
`ifdef USB2_SCHED_STATS_EN
   ,
   output logic [15:0] nak_count
`endif
);

   localparam logic [1:0] RESP_GO    = 2'd0;
   localparam logic [1:0] RESP_NAK   = 2'd1;
   localparam logic [1:0] RESP_STALL = 2'd2;
   localparam logic [7:0] ARM_LAST   = 8'(ARM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEL,
      S_CHECK,
      S_RESP,
      S_WAIT_DONE,
      S_ARM,
      S_TOGGLE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_sel;
   logic        r_in;
   logic        r_setup;
   logic [1:0]  r_resp;
   logic [7:0]  r_arm_cnt;
   logic        r_err_ovr;
   logic        r_err_tmo;
   logic        w_dir_in;
   logic        w_dir_ok;
   logic [1:0]  w_decision;
   logic        w_arm_tmo;

   // SETUP is an OUT-direction token regardless of tok_in
   assign w_dir_in  = r_in & ~r_setup;
   assign w_arm_tmo = (r_arm_cnt == ARM_LAST);

   // GO/NAK/STALL decision in priority order, sampled in S_CHECK
   always_comb begin
      w_decision = RESP_GO;
      w_dir_ok   = w_dir_in ? IN_MASK[r_sel] : OUT_MASK[r_sel];
      if (32'(r_sel) >= NUM_ENDP) begin
         w_decision = RESP_STALL;
      end else if (!w_dir_ok) begin
         w_decision = RESP_STALL;
      end else if (r_setup && (r_sel != 4'd0)) begin
         w_decision = RESP_STALL;
      end else if (w_dir_in) begin
         w_decision = buf_out_hasdata ? RESP_GO : RESP_NAK;
      end else begin
         w_decision = buf_in_ready ? RESP_GO : RESP_NAK;
      end
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:      if (tok_valid) w_state_nxt = S_SEL;
         S_SEL:       w_state_nxt = S_CHECK;
         S_CHECK:     w_state_nxt = S_RESP;
         S_RESP:      w_state_nxt = (r_resp == RESP_GO) ? S_WAIT_DONE : S_IDLE;
         S_WAIT_DONE: begin
            if (xfer_abort) begin
               w_state_nxt = S_IDLE;
            end else if (xfer_done) begin
               w_state_nxt = w_dir_in ? S_ARM : S_TOGGLE;
            end
         end
         S_ARM: begin
            if (buf_out_arm_ack) begin
               w_state_nxt = S_TOGGLE;
            end else if (w_arm_tmo) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_TOGGLE:    w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge phy_clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // token capture; endpoint select only changes on token acceptance
   always_ff @(posedge phy_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sel   <= 4'd0;
         r_in    <= 1'b0;
         r_setup <= 1'b0;
      end else if (r_state == S_IDLE && tok_valid) begin
         r_sel   <= tok_endp;
         r_in    <= tok_in;
         r_setup <= tok_setup;
      end
   end

   // decision register
   always_ff @(posedge phy_clk or negedge reset_n) begin
      if (!reset_n)                r_resp <= RESP_GO;
      else if (r_state == S_CHECK) r_resp <= w_decision;
   end

   // arm timeout counter, cleared before entering S_ARM
   always_ff @(posedge phy_clk or negedge reset_n) begin
      if (!reset_n)                    r_arm_cnt <= 8'd0;
      else if (r_state == S_WAIT_DONE) r_arm_cnt <= 8'd0;
      else if (r_state == S_ARM)       r_arm_cnt <= r_arm_cnt + 8'd1;
   end

   // sticky error flags, cleared only by reset
   always_ff @(posedge phy_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err_ovr <= 1'b0;
         r_err_tmo <= 1'b0;
      end else begin
         if (tok_valid && r_state != S_IDLE) r_err_ovr <= 1'b1;
         if (r_state == S_ARM && !buf_out_arm_ack && w_arm_tmo) r_err_tmo <= 1'b1;
      end
   end

`ifdef USB2_SCHED_STATS_EN
   logic [15:0] r_nak_cnt;

   // saturating count of NAK responses
   always_ff @(posedge phy_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_nak_cnt <= 16'd0;
      end else if (r_state == S_RESP && r_resp == RESP_NAK && r_nak_cnt != 16'hFFFF) begin
         r_nak_cnt <= r_nak_cnt + 16'd1;
      end
   end

   assign nak_count = r_nak_cnt;
`endif

   assign sel_endp        = r_sel;
   assign busy            = (r_state != S_IDLE);
   assign buf_out_arm     = (r_state == S_ARM);
   assign data_toggle_act = (r_state == S_TOGGLE);
   assign tok_resp_valid  = (r_state == S_RESP);
   assign tok_resp        = (r_state == S_RESP) ? r_resp : 2'd0;
   assign err_overrun     = r_err_ovr;
   assign err_timeout     = r_err_tmo;

endmodule

// File: tb/tb_usb2_xfer_sched.sv
// Testbench for usb2_xfer_sched: each transaction is turned into an expected
// per-cycle timeline (busy, select, response, arm, toggle, error flags) from
// the token/handshake timing rules; one negedge process compares the DUT
// against that timeline every cycle.
module tb_usb2_xfer_sched;
   localparam int          NUM_ENDP    = 3;
   localparam logic [15:0] IN_MASK     = 16'h0003;
   localparam logic [15:0] OUT_MASK    = 16'h0005;
   localparam int          ARM_TIMEOUT = 15;
   localparam int          NCYC        = 8192;

   logic       phy_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tok_valid = 1'b0;
   logic [3:0] tok_endp = 4'd0;
   logic       tok_in = 1'b0;
   logic       tok_setup = 1'b0;
   logic       xfer_done = 1'b0;
   logic       xfer_abort = 1'b0;
   logic       buf_out_hasdata = 1'b0;
   logic       buf_in_ready = 1'b0;
   logic       buf_out_arm_ack = 1'b0;
   logic [3:0] sel_endp;
   logic       buf_out_arm;
   logic       data_toggle_act;
   logic       tok_resp_valid;
   logic [1:0] tok_resp;
   logic       busy;
   logic       err_overrun;
   logic       err_timeout;
`ifdef USB2_SCHED_STATS_EN
   logic [15:0] nak_count;
`endif

   usb2_xfer_sched #(
      .NUM_ENDP(NUM_ENDP), .IN_MASK(IN_MASK), .OUT_MASK(OUT_MASK), .ARM_TIMEOUT(ARM_TIMEOUT)
   ) dut (
      .phy_clk(phy_clk), .reset_n(reset_n),
      .tok_valid(tok_valid), .tok_endp(tok_endp), .tok_in(tok_in), .tok_setup(tok_setup),
      .xfer_done(xfer_done), .xfer_abort(xfer_abort),
      .buf_out_hasdata(buf_out_hasdata), .buf_in_ready(buf_in_ready),
      .buf_out_arm_ack(buf_out_arm_ack),
      .sel_endp(sel_endp), .buf_out_arm(buf_out_arm), .data_toggle_act(data_toggle_act),
      .tok_resp_valid(tok_resp_valid), .tok_resp(tok_resp), .busy(busy),
      .err_overrun(err_overrun), .err_timeout(err_timeout)
`ifdef USB2_SCHED_STATS_EN
      , .nak_count(nak_count)
`endif
   );

   always #5 phy_clk = ~phy_clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // expected timeline
   bit e_busy[NCYC];
   bit e_arm[NCYC];
   bit e_tog[NCYC];
   bit e_rv[NCYC];
   bit e_selset[NCYC];
   bit e_nakinc[NCYC];
   int e_resp[NCYC];
   int e_sel[NCYC];
   int ovr_from = 1 << 30;
   int to_from  = 1 << 30;
   bit chk_en = 1'b0;
   int m_sel = 0;
   int m_nak = 0;
   int arm_seen = 0;
   int tog_seen = 0;
   int last_resp = -1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   always @(posedge phy_clk) cyc++;

   // compare process
   always @(negedge phy_clk) begin
      if (chk_en && cyc < NCYC) begin
         if (e_selset[cyc]) m_sel = e_sel[cyc];
         if (e_nakinc[cyc]) m_nak++;
         chk("busy", int'(busy), int'(e_busy[cyc]));
         chk("sel_endp", int'(sel_endp), m_sel);
         chk("buf_out_arm", int'(buf_out_arm), int'(e_arm[cyc]));
         chk("data_toggle_act", int'(data_toggle_act), int'(e_tog[cyc]));
         chk("tok_resp_valid", int'(tok_resp_valid), int'(e_rv[cyc]));
         if (e_rv[cyc]) chk("tok_resp", int'(tok_resp), e_resp[cyc]);
         chk("err_overrun", int'(err_overrun), int'(cyc >= ovr_from));
         chk("err_timeout", int'(err_timeout), int'(cyc >= to_from));
`ifdef USB2_SCHED_STATS_EN
         chk("nak_count", int'(nak_count), m_nak);
`endif
      end
      if (buf_out_arm) arm_seen++;
      if (data_toggle_act) tog_seen++;
      if (tok_resp_valid) last_resp = int'(tok_resp);
   end

   task automatic step();
      @(posedge phy_clk);
      #1;
   endtask

   // endk: 0 abort, 1 done, 2 done+abort together; k: ack cycle in ARM (>ARM_TIMEOUT = no ack)
   task automatic do_txn(input int e, input bit is_in, input bit setup, input bit hd, input bit rdy,
                         input int w, input bit ovr, input int endk, input int k);
      int t;
      int d;
      int resp;
      bit eff_in;
      logic [15:0] msk;
      t = cyc;
      eff_in = is_in && !setup;
      msk = eff_in ? IN_MASK : OUT_MASK;
      if (e >= NUM_ENDP)           resp = 2;
      else if (!msk[e])            resp = 2;
      else if (setup && e != 0)    resp = 2;
      else if (eff_in)             resp = hd ? 0 : 1;
      else                         resp = rdy ? 0 : 1;
      tok_valid = 1'b1; tok_endp = 4'(e); tok_in = is_in; tok_setup = setup;
      buf_out_hasdata = hd; buf_in_ready = rdy;
      e_selset[t+1] = 1'b1; e_sel[t+1] = e;
      for (int i = 1; i <= 3; i++) e_busy[t+i] = 1'b1;
      e_rv[t+3] = 1'b1; e_resp[t+3] = resp;
      if (resp == 1) e_nakinc[t+4] = 1'b1;
      step();
      tok_valid = 1'b0;
      step(); step(); step();
      if (resp != 0) return;
      for (int i = 0; i < w; i++) begin
         e_busy[cyc] = 1'b1;
         if (ovr && i == 0) begin
            tok_valid = 1'b1;
            tok_endp  = 4'($urandom_range(0, 15));
            tok_in    = 1'($urandom_range(0, 1));
            if (cyc + 1 < ovr_from) ovr_from = cyc + 1;
         end
         step();
         tok_valid = 1'b0;
      end
      d = cyc;
      e_busy[d] = 1'b1;
      if (endk == 0)      xfer_abort = 1'b1;
      else if (endk == 2) begin xfer_abort = 1'b1; xfer_done = 1'b1; end
      else                xfer_done = 1'b1;
      if (endk != 1) begin
         step(); xfer_abort = 1'b0; xfer_done = 1'b0;
         return;
      end
      if (!eff_in) begin
         e_busy[d+1] = 1'b1; e_tog[d+1] = 1'b1;
         step(); xfer_done = 1'b0;
         step();
         return;
      end
      if (k <= ARM_TIMEOUT) begin
         for (int c = d + 1; c <= d + k; c++) begin e_arm[c] = 1'b1; e_busy[c] = 1'b1; end
         e_busy[d+k+1] = 1'b1; e_tog[d+k+1] = 1'b1;
         step(); xfer_done = 1'b0;
         while (cyc < d + k) step();
         buf_out_arm_ack = 1'b1;
         step();
         buf_out_arm_ack = 1'b0;
         step();
      end else begin
         for (int c = d + 1; c <= d + ARM_TIMEOUT; c++) begin e_arm[c] = 1'b1; e_busy[c] = 1'b1; end
         if (d + ARM_TIMEOUT + 1 < to_from) to_from = d + ARM_TIMEOUT + 1;
         step(); xfer_done = 1'b0;
         while (cyc < d + ARM_TIMEOUT + 1) step();
      end
   endtask

   initial begin
      int r;
      repeat (3) @(posedge phy_clk);
      #1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_sel", int'(sel_endp), 0);
      chk("reset_arm", int'(buf_out_arm), 0);
      chk("reset_rv", int'(tok_resp_valid), 0);
      chk("reset_ovr", int'(err_overrun), 0);
      reset_n = 1'b1;
      step();
      chk_en = 1'b1;

      // IN endp1 with data, ack on the third ARM cycle
      do_txn(1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1, 3);
      chk("d1_resp_go", last_resp, 0);
      chk("d1_arm_cycles", arm_seen, 3);
      chk("d1_toggles", tog_seen, 1);

      // OUT endp2 not ready -> NAK, idle right after
      do_txn(2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1, 1);
      chk("d2_busy_low", int'(busy), 0);
      chk("d2_resp_nak", last_resp, 1);
      chk("d2_toggles", tog_seen, 1);
`ifdef USB2_SCHED_STATS_EN
      chk("d2_nak_count", int'(nak_count), 1);
`endif

      // STALL cases
      do_txn(5, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 1);
      chk("d3_stall_e5", last_resp, 2);
      do_txn(1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1, 1);
      chk("d3_stall_out_e1", last_resp, 2);
      do_txn(2, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1, 1);
      chk("d3_stall_setup_e2", last_resp, 2);
      chk("d3_toggles", tog_seen, 1);

      // IN GO with no ack -> timeout
      do_txn(0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1, 20);
      chk("d4_err_timeout", int'(err_timeout), 1);
      chk("d4_arm_cycles", arm_seen, 18);
      chk("d4_toggles", tog_seen, 1);

      // done+abort together, plus token during WAIT_DONE
      do_txn(0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b1, 2, 1);
      chk("d5_err_overrun", int'(err_overrun), 1);
      chk("d5_toggles", tog_seen, 1);
      chk("d5_arm_cycles", arm_seen, 18);

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         int e;
         int endk;
         repeat ($urandom_range(0, 2)) step();
         e = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 15)) : int'($urandom_range(0, 2));
         r = int'($urandom_range(0, 9));
         endk = (r == 0) ? 0 : ((r == 1) ? 2 : 1);
         do_txn(e, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                endk, int'($urandom_range(1, 18)));
      end

      // reset in the middle of ARM
      step();
      chk_en = 1'b0;
      tok_valid = 1'b1; tok_endp = 4'd1; tok_in = 1'b1; tok_setup = 1'b0; buf_out_hasdata = 1'b1;
      step();
      tok_valid = 1'b0;
      step(); step(); step();
      xfer_done = 1'b1;
      step();
      xfer_done = 1'b0;
      step();
      #2;
      chk("rst_pre_arm", int'(buf_out_arm), 1);
      reset_n = 1'b0;
      #1;
      chk("rst_arm", int'(buf_out_arm), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_sel", int'(sel_endp), 0);
      chk("rst_tog", int'(data_toggle_act), 0);
      chk("rst_rv", int'(tok_resp_valid), 0);
      chk("rst_ovr", int'(err_overrun), 0);
      chk("rst_tmo", int'(err_timeout), 0);
      step(); step();
      reset_n = 1'b1;
      step();
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_sel", int'(sel_endp), 0);
      chk("post_rst_tog", int'(data_toggle_act), 0);
      tok_valid = 1'b1; tok_endp = 4'd2; tok_in = 1'b0; tok_setup = 1'b0; buf_in_ready = 1'b0;
      step();
      tok_valid = 1'b0;
      chk("post_rst_sel2", int'(sel_endp), 2);
      chk("post_rst_busy1", int'(busy), 1);
      step(); step();
      chk("post_rst_rv", int'(tok_resp_valid), 1);
      chk("post_rst_nak", int'(tok_resp), 1);
      step();
      chk("post_rst_idle", int'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // watchdog
   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
